// File: rtl/demux_1x8_nbit_reg.sv
// Registered 1-to-8 demultiplexer.
// One n-bit word per cycle is steered into one of eight holding registers.
// The destination comes either from an explicit select or from an internal
// pointer that advances after every auto-mode write.
// Every output is a register, so there is no combinational path from x,
// select or load to any output.
module demux_1x8_nbit_reg #(
  parameter int n = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] x,
  input  logic [2:0]   select,
  input  logic         load,
  input  logic         auto,
  input  logic         clear,
  output logic [n-1:0] y0,
  output logic [n-1:0] y1,
  output logic [n-1:0] y2,
  output logic [n-1:0] y3,
  output logic [n-1:0] y4,
  output logic [n-1:0] y5,
  output logic [n-1:0] y6,
  output logic [n-1:0] y7,
  output logic [7:0]   updated,
  output logic [2:0]   ptr
);

  logic [n-1:0] channel_q [8];
  logic [n-1:0] channel_d [8];
  logic [7:0]   updated_q;
  logic [7:0]   updated_d;
  logic [2:0]   ptr_q;
  logic [2:0]   ptr_d;
  logic [2:0]   destination;

  // Pick the write target: the pointer in auto mode, otherwise the explicit select.
  always_comb begin
    destination = auto ? ptr_q : select;
  end

  // Next-state logic: clear beats load; an idle cycle holds data and drops the update pulse.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      channel_d[k] = channel_q[k];
    end
    updated_d = 8'h00;
    ptr_d     = ptr_q;
    if (clear) begin
      for (int k = 0; k < 8; k++) begin
        channel_d[k] = '0;
      end
      ptr_d = 3'd0;
    end else if (load) begin
      channel_d[destination] = x;
      updated_d              = 8'h01 << destination;
      if (auto) begin
        ptr_d = ptr_q + 3'd1;
      end
    end
  end

  // State registers with a synchronous active-low reset that overrides everything else.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 8; k++) begin
        channel_q[k] <= '0;
      end
      updated_q <= 8'h00;
      ptr_q     <= 3'd0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        channel_q[k] <= channel_d[k];
      end
      updated_q <= updated_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y0      = channel_q[0];
  assign y1      = channel_q[1];
  assign y2      = channel_q[2];
  assign y3      = channel_q[3];
  assign y4      = channel_q[4];
  assign y5      = channel_q[5];
  assign y6      = channel_q[6];
  assign y7      = channel_q[7];
  assign updated = updated_q;
  assign ptr     = ptr_q;

endmodule

// File: tb/tb_demux_1x8_nbit_reg.sv
// Testbench for demux_1x8_nbit_reg.
// The stimulus side predicts each cycle's registered outputs and queues them.
// A monitor on the falling edge pops each prediction and compares it with the outputs.
module tb_demux_1x8_nbit_reg;

  localparam int N = 6;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] x;
  logic [2:0]   select;
  logic         load;
  logic         auto;
  logic         clear;
  logic [N-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0]   updated;
  logic [2:0]   ptr;

  logic [N-1:0] yv [8];

  typedef struct packed {
    logic [7:0][N-1:0] y;
    logic [7:0]        upd;
    logic [2:0]        ptr;
  } expect_t;

  expect_t expQ[$];
  expect_t expCur;

  int checks = 0;
  int errors = 0;

  // Reference state, updated with plain integer arithmetic.
  int mY [8];
  int mUpd;
  int mPtr;

  demux_1x8_nbit_reg #(.n(N)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .select(select), .load(load),
    .auto(auto), .clear(clear),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .updated(updated), .ptr(ptr)
  );

  assign yv[0] = y0;
  assign yv[1] = y1;
  assign yv[2] = y2;
  assign yv[3] = y3;
  assign yv[4] = y4;
  assign yv[5] = y5;
  assign yv[6] = y6;
  assign yv[7] = y7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value, counting the check and reporting a failure.
  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the result, queue it, and step past the edge.
  task automatic applyStimulus(input logic rst, input logic clr, input logic ld,
                               input logic au, input logic [2:0] sel, input int xv);
    expect_t e;
    int dest;
    reset_n = rst;
    clear   = clr;
    load    = ld;
    auto    = au;
    select  = sel;
    x       = xv[N-1:0];
    if (!rst || clr) begin
      for (int k = 0; k < 8; k++) mY[k] = 0;
      mUpd = 0;
      mPtr = 0;
    end else if (ld) begin
      dest     = au ? mPtr : int'(sel);
      mY[dest] = xv % (1 << N);
      mUpd     = 1 << dest;
      if (au) mPtr = (mPtr + 1) % 8;
    end else begin
      mUpd = 0;
    end
    for (int k = 0; k < 8; k++) e.y[k] = mY[k][N-1:0];
    e.upd = mUpd[7:0];
    e.ptr = mPtr[2:0];
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle presents a new registered result, checked mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expCur = expQ.pop_front();
      for (int k = 0; k < 8; k++) begin
        checkOutput($sformatf("y%0d", k), int'(yv[k]), int'(expCur.y[k]));
      end
      checkOutput("updated", int'(updated), int'(expCur.upd));
      checkOutput("ptr", int'(ptr), int'(expCur.ptr));
    end
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; load = 1'b0; auto = 1'b0; select = 3'd0; x = '0;
    for (int k = 0; k < 8; k++) mY[k] = 0;
    mUpd = 0;
    mPtr = 0;

    // Reset held two cycles while a load is requested.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 'h2A);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 'h2A);
    checkOutput("reset_updated", int'(updated), 0);

    // Select mode, consecutive writes.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 5);
    checkOutput("sel_y3", int'(y3), 5);
    checkOutput("sel_upd3", int'(updated), 'h08);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 63);
    checkOutput("sel_y7", int'(y7), 63);
    checkOutput("sel_upd7", int'(updated), 'h80);

    // Auto mode with pointer wrap: nine writes.
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 7)), i);
    end
    checkOutput("wrap_y0", int'(y0), 9);
    checkOutput("wrap_y7", int'(y7), 8);
    checkOutput("wrap_ptr", int'(ptr), 1);
    checkOutput("wrap_upd", int'(updated), 'h01);

    // Clear versus load: set up ptr=4 and y2=12 first.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 20 + i);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 12);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 33);
    checkOutput("clr_y4", int'(y4), 0);
    checkOutput("clr_ptr", int'(ptr), 0);

    // Mid-burst reset at ptr=5, then the next load lands in channel 0.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 40 + i);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 50);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 17);
    checkOutput("rst_y0", int'(y0), 17);
    checkOutput("rst_ptr", int'(ptr), 1);

    // Idle hold with a toggling select.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 40);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'(i), 0);
    checkOutput("idle_y6", int'(y6), 40);
    checkOutput("idle_upd", int'(updated), 0);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 5),
                    ($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), int'($urandom_range(0, 63)));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0);

    // Let the monitor drain outstanding predictions, within a bound.
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    #6;
    checkOutput("queue_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x8_nbit_reg.md
Name: demux_1x8_nbit_reg

Overview:
Registered 1-to-8 demultiplexer. It is the write-side counterpart of the 8x1 n-bit output mux in the parking lot occupancy counter. A single n-bit value (for example a per-level occupancy count) is steered into one of eight holding registers, either by explicit select or by an internal auto-incrementing pointer. The eight registers then feed the display/readback mux and per-level comparators.

Parameters:
n, 6, data width of the input and of each of the eight holding registers

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset_n  input  1  synchronous, active-low reset
x  input  n  data word to store
select  input  3  destination channel when auto=0
load  input  1  write strobe; one write per cycle while high
auto  input  1  1 = use internal pointer as destination; 0 = use select
clear  input  1  synchronous clear of all channels and the pointer
y0..y7  output  n each  holding-register contents for channels 0..7
updated  output  8  one-hot pulse; bit k high for one cycle after channel k is written
ptr  output  3  current auto-mode pointer (next destination when auto=1)

Behaviour:
- Reset (reset_n=0 at a rising clk edge):
  - y0..y7 = 0, updated = 0, ptr = 0.
  - Reset overrides clear, load and auto.
- Priority, highest first: reset_n=0, then clear=1, then load=1.
- Clear (reset_n=1, clear=1):
  - y0..y7 = 0, ptr = 0, updated = 0.
  - Any load in the same cycle is dropped.
- Load, auto=0 (reset_n=1, clear=0, load=1):
  - At the edge, y[select] <= x and updated <= (1 << select).
  - ptr is unchanged.
- Load, auto=1:
  - At the edge, y[ptr] <= x, updated <= (1 << ptr), ptr <= ptr + 1 modulo 8 (7 wraps to 0).
  - select is ignored.
- No load and no clear: all y hold; updated <= 0; ptr holds.
- Latency: a write is visible on y[k] and updated[k] one cycle after the sampling edge. No combinational path from x, select or load to any output.
- Back-to-back loads:
  - One write is accepted per cycle.
  - updated stays asserted on consecutive cycles, with the bit following the destination each cycle.
  - Repeated writes to the same channel keep updated[k] high continuously.
- Unwritten channels hold their value indefinitely.
- Switching auto 0->1 or 1->0 takes effect on the same cycle it is sampled. ptr is not reset by a mode change.
- updated always has at most one bit set.
- x is stored verbatim; no truncation or sign handling.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with load=1, x=6'h2A -> y0..y7=0, updated=0, ptr=0 after release.
- Select mode: auto=0; write x=5 to select=3, then x=63 to select=7 on consecutive cycles -> y3=5 with updated=8'h08, next cycle y7=63 with updated=8'h80; all other channels remain 0.
- Auto-mode wrap: auto=1; nine consecutive loads x=1..9 -> y0..y7=9,2,3,4,5,6,7,8 (channel 0 is overwritten by the 9th load); ptr sequence 1,2,...,7,0,1; updated walks 01,02,...,80,01.
- Clear vs load: with y2=12 and ptr=4, assert clear=1 and load=1 (auto=1, x=33) together -> all y=0, ptr=0, updated=0; y4 is not written.
- Mid-operation reset: during an auto-mode burst at ptr=5, drive reset_n=0 for one cycle with load=1 -> all outputs 0, ptr=0; the next load (x=17) lands in y0.
- Idle hold: write y6=40, then idle 10 cycles with select toggling and load=0 -> y6 stays 40; updated=0 from the second cycle on.
